alu_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one combinational ADDU ALU (Src_1/Src_2/ADDU_ctrl in; ALU_Result/ALU_Carry out) among NUM_REQ requesters.
- Accepts one operand pair per transaction over a valid/ready handshake, drives the ALU for one cycle, registers the result, and returns it on a shared response channel tagged with the requester ID.
- Sits between the requesting units and the single ALU instance in the datapath.

---
 rtl/alu_arbiter.sv | 160 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external ADDU ALU among NUM_REQ requesters.
// Optional feature macro: ALU_ARB_PERF_EN (adds perf_ops / perf_stall counters).
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_src1,
  input  logic [32*NUM_REQ-1:0] req_src2,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_result,
  output logic                  resp_carry,
  output logic [31:0]           Src_1,
  output logic [31:0]           Src_2,
  output logic [5:0]            ADDU_ctrl,
  input  logic [31:0]           ALU_Result,
  input  logic                  ALU_Carry
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]           perf_ops,
  output logic [31:0]           perf_stall
`endif
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] EXEC = 2'b01;
  localparam logic [1:0] RESP = 2'b10;
  localparam logic [5:0] OP_ADDU = 6'b001001;

  logic [1:0]      state_r;
  logic [ID_W-1:0] last_grant_r;
  logic [ID_W-1:0] id_r;
  logic [31:0]     src1_r;
  logic [31:0]     src2_r;
  logic [5:0]      ctrl_r;
  logic [31:0]     result_r;
  logic            carry_r;
  logic            resp_valid_r;
  logic            grant_valid_s;
  logic [ID_W-1:0] grant_id_s;

  // Round-robin pick: first valid requester after the last one served, wrapping.
  always_comb begin
    logic [ID_W-1:0] idx_v;
    grant_valid_s = 1'b0;
    grant_id_s    = '0;
    idx_v         = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_v = ID_W'((int'(last_grant_r) + k) % NUM_REQ);
      if (req_valid[idx_v] && !grant_valid_s) begin
        grant_valid_s = 1'b1;
        grant_id_s    = idx_v;
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
  end

  // Accept is only offered from IDLE, to the chosen requester.
  always_comb begin
    req_ready = '0;
    if ((state_r == IDLE) && grant_valid_s) begin
      req_ready[grant_id_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Transaction sequencer; ALU drive registers are loaded on grant so they are live only in EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= ID_W'(NUM_REQ - 1);
      id_r         <= '0;
      src1_r       <= 32'd0;
      src2_r       <= 32'd0;
      ctrl_r       <= 6'b000000;
      result_r     <= 32'd0;
      carry_r      <= 1'b0;
      resp_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            src1_r  <= req_src1[int'(grant_id_s)*32 +: 32];
            src2_r  <= req_src2[int'(grant_id_s)*32 +: 32];
            ctrl_r  <= OP_ADDU;
            id_r    <= grant_id_s;
            state_r <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          result_r     <= ALU_Result;
          carry_r      <= ALU_Carry;
          src1_r       <= 32'd0;
          src2_r       <= 32'd0;
          ctrl_r       <= 6'b000000;
          resp_valid_r <= 1'b1;
          state_r      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            last_grant_r <= id_r;
            resp_valid_r <= 1'b0;
            state_r      <= IDLE;
          end else begin
            state_r      <= RESP;
          end
        end
        default: begin
          src1_r       <= 32'd0;
          src2_r       <= 32'd0;
          ctrl_r       <= 6'b000000;
          resp_valid_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign Src_1       = src1_r;
  assign Src_2       = src2_r;
  assign ADDU_ctrl   = ctrl_r;
  assign resp_valid  = resp_valid_r;
  assign resp_id     = id_r;
  assign resp_result = result_r;
  assign resp_carry  = carry_r;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_ops_r;
  logic [31:0] perf_stall_r;

  // Accepted responses and backpressured response cycles, both free-running with wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_r   <= 32'd0;
      perf_stall_r <= 32'd0;
    end else if (state_r == RESP) begin
      if (resp_ready) begin
        perf_ops_r <= perf_ops_r + 32'd1;
      end else begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
    end else begin
      perf_ops_r <= perf_ops_r;
    end
  end

  assign perf_ops   = perf_ops_r;
  assign perf_stall = perf_stall_r;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter with a behavioural ADDU ALU.
module tb_alu_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_src1;
  logic [32*NUM_REQ-1:0] req_src2;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_result;
  logic                  resp_carry;
  logic [31:0]           Src_1;
  logic [31:0]           Src_2;
  logic [5:0]            ADDU_ctrl;
  logic [31:0]           ALU_Result;
  logic                  ALU_Carry;
`ifdef ALU_ARB_PERF_EN
  logic [31:0]           perf_ops;
  logic [31:0]           perf_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result), .resp_carry(resp_carry),
    .Src_1(Src_1), .Src_2(Src_2), .ADDU_ctrl(ADDU_ctrl),
    .ALU_Result(ALU_Result), .ALU_Carry(ALU_Carry)
`ifdef ALU_ARB_PERF_EN
    , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
  );

  // Shared ADDU ALU: adds only when the add opcode is presented.
  assign {ALU_Carry, ALU_Result} = (ADDU_ctrl == 6'b001001) ?
                                   ({1'b0, Src_1} + {1'b0, Src_2}) : 33'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  exp_id;
    logic [31:0] exp_src1;
    logic [31:0] exp_src2;
    logic [31:0] exp_res;
    logic        exp_carry;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requester i presents src1 = a + i*0x100 and src2 = b + i.
  task automatic set_req(input logic [3:0] mask, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_src1[i*32 +: 32] = a + 32'(i) * 32'h100;
      req_src2[i*32 +: 32] = b + 32'(i);
    end
    req_valid = mask;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = 4'b0000;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int ids[5];
    int cyc[5];
    int got;
    logic [3:0] one_hot;

    vecs[0] = '{4'b0001, 32'h5,        32'h7,        2'd0, 32'h5,        32'h7,        32'hC,        1'b0};
    vecs[1] = '{4'b0001, 32'hFFFFFFFF, 32'h1,        2'd0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1};
    vecs[2] = '{4'b0001, 32'h80000000, 32'h80000000, 2'd0, 32'h80000000, 32'h80000000, 32'h0,        1'b1};
    vecs[3] = '{4'b1111, 32'h10,       32'h20,       2'd1, 32'h110,      32'h21,       32'h131,      1'b0};
    vecs[4] = '{4'b1001, 32'h1000,     32'h1,        2'd3, 32'h1300,     32'h4,        32'h1304,     1'b0};
    vecs[5] = '{4'b1001, 32'h1000,     32'h1,        2'd0, 32'h1000,     32'h1,        32'h1001,     1'b0};
    vecs[6] = '{4'b0110, 32'hFFFFFF00, 32'h0,        2'd1, 32'h0,        32'h1,        32'h1,        1'b0};
    vecs[7] = '{4'b0110, 32'hFFFFFD00, 32'hFF,       2'd2, 32'hFFFFFF00, 32'h101,      32'h1,        1'b1};

    req_src1 = '0;
    req_src2 = '0;
    do_reset();
    @(negedge clk);
    check("reset_resp_valid", 64'(resp_valid), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_ctrl", 64'(ADDU_ctrl), 64'd0);
    check("reset_src1", 64'(Src_1), 64'd0);
    @(posedge clk); #1;

    // Table: each vector is one full IDLE -> EXEC -> RESP transaction.
    for (int v = 0; v < 8; v++) begin
      set_req(vecs[v].mask, vecs[v].a, vecs[v].b);
      resp_ready = 1'b1;
      one_hot = 4'b0001 << vecs[v].exp_id;
      @(negedge clk);
      check($sformatf("v%0d_ready", v), 64'(req_ready), 64'(one_hot));
      check($sformatf("v%0d_idle_ctrl", v), 64'(ADDU_ctrl), 64'd0);
      @(posedge clk); #1 req_valid = 4'b0000;
      @(negedge clk);
      check($sformatf("v%0d_exec_ctrl", v), 64'(ADDU_ctrl), 64'h09);
      check($sformatf("v%0d_src1", v), 64'(Src_1), 64'(vecs[v].exp_src1));
      check($sformatf("v%0d_src2", v), 64'(Src_2), 64'(vecs[v].exp_src2));
      check($sformatf("v%0d_exec_ready", v), 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("v%0d_resp_valid", v), 64'(resp_valid), 64'd1);
      check($sformatf("v%0d_resp_id", v), 64'(resp_id), 64'(vecs[v].exp_id));
      check($sformatf("v%0d_result", v), 64'(resp_result), 64'(vecs[v].exp_res));
      check($sformatf("v%0d_carry", v), 64'(resp_carry), 64'(vecs[v].exp_carry));
      check($sformatf("v%0d_resp_ctrl", v), 64'(ADDU_ctrl), 64'd0);
      @(posedge clk); #1;
    end

    // Round robin: all requesters held valid from reset.
    do_reset();
    set_req(4'b1111, 32'h100, 32'h0);
    got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        ids[got] = int'(resp_id);
        cyc[got] = c;
        if (got == 0) check("rr_first_result", 64'(resp_result), 64'h100);
        got++;
      end
    end
    check("rr_count", 64'(got), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < got) begin
        check($sformatf("rr_id%0d", k), 64'(ids[k]), 64'(k % 4));
        if (k > 0) check($sformatf("rr_gap%0d", k), 64'(cyc[k] - cyc[k-1]), 64'd3);
      end
    end
    req_valid = 4'b0000;

    // Backpressure: response held 5 cycles while others wait.
    do_reset();
    set_req(4'b0100, 32'h3, 32'h4);
    resp_ready = 1'b0;
    @(negedge clk);
    check("bp_ready", 64'(req_ready), 64'b0100);
    @(posedge clk); #1 req_valid = 4'b1011;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_valid%0d", k), 64'(resp_valid), 64'd1);
      check($sformatf("bp_id%0d", k), 64'(resp_id), 64'd2);
      check($sformatf("bp_result%0d", k), 64'(resp_result), 64'h209);
      check($sformatf("bp_noready%0d", k), 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_still_valid", 64'(resp_valid), 64'd1);
`ifdef ALU_ARB_PERF_EN
    check("perf_stall", 64'(perf_stall), 64'd5);
    check("perf_ops_before", 64'(perf_ops), 64'd0);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_after_valid", 64'(resp_valid), 64'd0);
    check("bp_next_grant", 64'(req_ready), 64'b1000);
`ifdef ALU_ARB_PERF_EN
    check("perf_ops_after", 64'(perf_ops), 64'd1);
`endif
    req_valid = 4'b0000;

    // Reset in EXEC discards the transaction; requester 0 wins afterwards.
    do_reset();
    set_req(4'b0010, 32'h0, 32'h0);
    @(negedge clk);
    check("rst_grant1", 64'(req_ready), 64'b0010);
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 4'b0011;
    @(negedge clk);
    check("rst_in_exec_ctrl", 64'(ADDU_ctrl), 64'h09);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_ctrl", 64'(ADDU_ctrl), 64'd0);
    check("rst_regrant0", 64'(req_ready), 64'b0001);
    @(posedge clk); #1 req_valid = 4'b0010;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_resp0_id", 64'(resp_id), 64'd0);
    check("rst_resp0_valid", 64'(resp_valid), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_regrant1", 64'(req_ready), 64'b0010);
    req_valid = 4'b0000;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
